// File: rtl/data_ram_be.sv
// data_ram_be: single-port word RAM with per-byte write enables, a
// request/response handshake and a clear sweep that runs after reset.
// After reset the block spends exactly DEPTH cycles in INIT, zeroing one word
// per cycle, then sits in IDLE accepting one request per cycle. Reads answer
// one cycle after acceptance. Out-of-range reads are flagged with rsp_err, and
// out-of-range writes are silently dropped.
// Optional feature macro: DATA_RAM_PARITY_EN adds one even-parity bit per byte.
// A read whose stored parity disagrees with its data raises rsp_perr.
module data_ram_be #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                rsp_perr,
  output logic                init_done
);

  localparam int NB    = DATA_W / 8;
  localparam int CNT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // Depth widened by one bit so the range compare cannot overflow.
  localparam logic [ADDR_W:0]  DEPTH_A  = (ADDR_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DEPTH - 1);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_IDLE = 1'b1
  } state_t;

  state_t            state_r;
  state_t            state_nx_s;
  logic [CNT_W-1:0]  cnt_r;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              accept_s;
  logic              in_range_s;
  logic [CNT_W-1:0]  idx_s;

`ifdef DATA_RAM_PARITY_EN
  logic [NB-1:0] par [DEPTH];

  // Even parity of one byte: the stored bit makes the total count of ones even.
  function automatic logic byte_par(input logic [7:0] b);
    return ^b;
  endfunction

  // Returns 1 when any byte of the word disagrees with its stored parity bit.
  function automatic logic word_par_err(input logic [DATA_W-1:0] w,
                                        input logic [NB-1:0]     p);
    logic e;
    e = 1'b0;
    for (int b = 0; b < NB; b++) begin
      e = e | (byte_par(w[8*b +: 8]) ^ p[b]);
    end
    return e;
  endfunction
`endif

  // Handshake and address decode for the current request.
  always_comb begin
    accept_s   = req_valid && (state_r == ST_IDLE);
    in_range_s = ({1'b0, req_addr} < DEPTH_A);
    idx_s      = req_addr[CNT_W-1:0];
  end

  assign req_ready = (state_r == ST_IDLE);
  assign init_done = (state_r == ST_IDLE);

  // State register; reset always restarts the clear sweep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_INIT;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next state: leave INIT after the last word has been cleared.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_INIT: begin
        if (cnt_r == LAST_IDX) begin
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_INIT;
        end
      end
      ST_IDLE: state_nx_s = ST_IDLE;
      default: state_nx_s = ST_INIT;
    endcase
  end

  // Sweep address counter, advancing once per INIT cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (state_r == ST_INIT) begin
      cnt_r <= cnt_r + 1'b1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Storage writes: zero fill during INIT, byte-masked writes once IDLE.
  always_ff @(posedge clk) begin
    if (state_r == ST_INIT) begin
      mem[cnt_r] <= '0;
`ifdef DATA_RAM_PARITY_EN
      par[cnt_r] <= '0;
`endif
    end else if (accept_s && req_write && in_range_s) begin
      for (int b = 0; b < NB; b++) begin
        if (req_be[b]) begin
          mem[idx_s][8*b +: 8] <= req_wdata[8*b +: 8];
`ifdef DATA_RAM_PARITY_EN
          par[idx_s][b] <= byte_par(req_wdata[8*b +: 8]);
`endif
        end
      end
    end
  end

  // Read response: a one-cycle strobe, with all data fields zero while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      if (accept_s && !req_write) begin
        rsp_valid <= 1'b1;
        if (in_range_s) begin
          rsp_rdata <= mem[idx_s];
        end else begin
          rsp_err <= 1'b1;
        end
      end
    end
  end

`ifdef DATA_RAM_PARITY_EN
  // Parity flag for in-range reads; out-of-range reads never set it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_perr <= 1'b0;
    end else if (accept_s && !req_write && in_range_s) begin
      rsp_perr <= word_par_err(mem[idx_s], par[idx_s]);
    end else begin
      rsp_perr <= 1'b0;
    end
  end
`else
  assign rsp_perr = 1'b0;
`endif

endmodule

// File: tb/tb_data_ram_be.sv
// Self-checking bench for data_ram_be with the default parameters
// (DATA_W=16, DEPTH=256, ADDR_W=16).
// Read expectations come from a reference memory and are queued when a read is
// driven. A negedge monitor pops each entry and compares data, error flags and
// the response cycle.
module tb_data_ram_be;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic [1:0]  req_be;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_perr;
  logic        init_done;

  typedef struct {
    logic [15:0] d;
    logic        e;
    logic        p;
    int          c;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] model [256];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc   = 0;

  data_ram_be dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .rsp_perr  (rsp_perr),
    .init_done (init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count rising edges; the response cycle is checked against this count.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Response monitor, sampling on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rsp_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_rsp", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("rsp_rdata", {16'd0, rsp_rdata}, {16'd0, e.d});
          chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.e});
          chk("rsp_perr", {31'd0, rsp_perr}, {31'd0, e.p});
          chk("rsp_cycle", cyc, e.c);
        end
      end else begin
        chk("idle_rsp_zero", {14'd0, rsp_rdata, rsp_err, rsp_perr}, 32'd0);
      end
    end
  end

  task automatic clr_model();
    for (int i = 0; i < 256; i++) model[i] = 16'h0000;
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d, input logic [1:0] be);
    chk("ready_at_wr", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_write = 1'b1; req_addr = a; req_wdata = d; req_be = be;
    if (a < 16'd256) begin
      if (be[0]) model[a][7:0]  = d[7:0];
      if (be[1]) model[a][15:8] = d[15:8];
    end
    @(posedge clk); #1;
    req_valid = 1'b0; req_write = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, input logic perr_exp);
    exp_t e;
    chk("ready_at_rd", {31'd0, req_ready}, 32'd1);
    e.d = (a < 16'd256) ? model[a] : 16'h0000;
    e.e = (a >= 16'd256) ? 1'b1 : 1'b0;
    e.p = perr_exp;
    e.c = cyc + 1;
    sb.push_back(e);
    req_valid = 1'b1; req_write = 1'b0; req_addr = a; req_wdata = 16'h0000; req_be = 2'b00;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  // Count cycles until ready rises. When stray is set, a write is offered
  // during the sweep that must not be accepted.
  task automatic measure_sweep(input string tag, input bit stray);
    int n;
    n = 0;
    while (!req_ready && n < 1000) begin
      @(posedge clk); #1;
      n++;
      if (stray && n == 50) begin
        req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h0030;
        req_wdata = 16'hBEEF; req_be = 2'b11;
      end
      if (n == 60) begin
        req_valid = 1'b0; req_write = 1'b0;
      end
    end
    chk(tag, n, 32'd256);
    chk("init_done_after_sweep", {31'd0, init_done}, 32'd1);
  endtask

  task automatic chk_outs_zero(input string tag);
    chk(tag, {28'd0, req_ready, rsp_valid, rsp_err, rsp_perr}, 32'd0);
    chk({tag, "_rdata"}, {16'd0, rsp_rdata}, 32'd0);
    chk({tag, "_init"}, {31'd0, init_done}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0;
    req_addr = 16'h0000; req_wdata = 16'h0000; req_be = 2'b00;
    clr_model();
    repeat (3) @(posedge clk);
    #1;
    chk_outs_zero("reset_state");
    rst_n = 1'b1;
    chk("ready_after_release", {31'd0, req_ready}, 32'd0);
    measure_sweep("first_sweep_len", 1'b1);

    // Cleared memory, including the last word and the word the stray write hit.
    rd(16'h00FF, 1'b0);
    rd(16'h0030, 1'b0);

    // Byte-enable merging.
    wr(16'h0010, 16'hABCD, 2'b11);
    wr(16'h0010, 16'h1234, 2'b01);
    rd(16'h0010, 1'b0);
    wr(16'h0010, 16'h9999, 2'b00);
    rd(16'h0010, 1'b0);
    wr(16'h0011, 16'h7788, 2'b10);
    rd(16'h0011, 1'b0);

    // Back-to-back reads give one response per cycle, in order.
    wr(16'h0001, 16'h1111, 2'b11);
    wr(16'h0002, 16'h2222, 2'b11);
    wr(16'h0003, 16'h3333, 2'b11);
    rd(16'h0001, 1'b0);
    rd(16'h0002, 1'b0);
    rd(16'h0003, 1'b0);

    // Out-of-range accesses; the dropped write must not alias onto word 0.
    wr(16'h0100, 16'hFFFF, 2'b11);
    rd(16'h0100, 1'b0);
    rd(16'h0000, 1'b0);
    rd(16'hFFFF, 1'b0);

    // A read straight after a write sees the new data.
    wr(16'h0020, 16'h5A5A, 2'b11);
    rd(16'h0020, 1'b0);
    repeat (2) @(posedge clk);
    #1;

    // Parity: corrupt the low byte of word 5 behind the parity bits.
    wr(16'h0005, 16'h00F0, 2'b11);
`ifdef DATA_RAM_PARITY_EN
    dut.mem[5] = dut.mem[5] ^ 16'h0001;
    model[5] = model[5] ^ 16'h0001;
    rd(16'h0005, 1'b1);
`else
    rd(16'h0005, 1'b0);
`endif
    repeat (2) @(posedge clk);
    #1;

    // Reset while a read response is pending: the response is dropped.
    rd(16'h0020, 1'b0);
    rst_n = 1'b0;
    #1;
    chk_outs_zero("reset_pending_rsp");
    sb.delete();
    clr_model();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    measure_sweep("sweep_after_op_reset", 1'b0);

    // Reset pulsed at sweep cycle 100, so the sweep restarts from the beginning.
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    chk("ready_mid_sweep", {31'd0, req_ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk_outs_zero("reset_mid_sweep");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    measure_sweep("sweep_after_mid_reset", 1'b0);
    rd(16'h0020, 1'b0);
    rd(16'h0010, 1'b0);
    repeat (3) @(posedge clk);
    #1;

    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
